// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer: state encoding,
// saturating-counter width and small constant/arithmetic helpers.
package pll_seq_pkg;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        DELAY     = 2'd2,
        RUN       = 2'd3
    } seq_state_e;

    localparam int SAT_W = 8;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Event counters hold at all-ones instead of wrapping.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v);
        return (v == {SAT_W{1'b1}}) ? v : v + SAT_W'(1);
    endfunction

endpackage

// File: rtl/pll_rst_seq_if.sv
// PLL-facing and reset-consumer-facing signals of the reset sequencer.
interface pll_rst_seq_if;
    import pll_seq_pkg::*;

    logic             pll_lock_i;
    logic             pll_reset_o;
    logic             sys_rst_n_o;
    logic             locked_o;
    logic [SAT_W-1:0] loss_cnt_o;
    logic [SAT_W-1:0] timeout_cnt_o;

    modport master (
        input  pll_lock_i,
        output pll_reset_o, sys_rst_n_o, locked_o, loss_cnt_o, timeout_cnt_o
    );

    modport slave (
        output pll_lock_i,
        input  pll_reset_o, sys_rst_n_o, locked_o, loss_cnt_o, timeout_cnt_o
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic q_r;

    // Capture stage followed by the settling stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            q_r    <= 1'b0;
        end else begin
            meta_r <= d;
            q_r    <= meta_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: pulses PLL reset, waits for stable lock (with timeout),
// delays, then releases the PLL-domain reset; re-sequences on lock loss.
module pll_rst_seq
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYC      = 16,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 65536,
    parameter int RELEASE_DLY_CYC  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    pll_rst_seq_if.master     bus
);

    localparam int CNT_MAX = max_of(max_of(PLL_RST_CYC, LOCK_TIMEOUT_CYC),
                                    max_of(LOCK_STABLE_CYC, RELEASE_DLY_CYC));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int STB_W   = $clog2(LOCK_STABLE_CYC + 1);

    seq_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [STB_W-1:0] stab_r;
    logic [STB_W-1:0] stab_nxt_s;
    logic             stab_done_s;
    logic             lk_s;
    logic             pll_reset_r;
    logic             sys_rst_n_r;
    logic             locked_r;
    logic [SAT_W-1:0] loss_r;
    logic [SAT_W-1:0] tmo_r;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.pll_lock_i),
        .q     (lk_s)
    );

    // Next stable-lock count and the "lock has been stable long enough" flag.
    always_comb begin
        stab_nxt_s  = {STB_W{1'b0}};
        stab_done_s = 1'b0;
        if (lk_s) begin
            stab_nxt_s  = stab_r + STB_W'(1);
            stab_done_s = (stab_nxt_s == STB_W'(LOCK_STABLE_CYC));
        end else begin
            stab_nxt_s  = {STB_W{1'b0}};
            stab_done_s = 1'b0;
        end
    end

    // Sequencer FSM; outputs are updated on the same edge as the state so they
    // always match the state they decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= PLL_RST;
            cnt_r       <= CNT_W'(PLL_RST_CYC);
            stab_r      <= {STB_W{1'b0}};
            pll_reset_r <= 1'b1;
            sys_rst_n_r <= 1'b0;
            locked_r    <= 1'b0;
            loss_r      <= {SAT_W{1'b0}};
            tmo_r       <= {SAT_W{1'b0}};
        end else begin
            case (state_r)
                PLL_RST: begin
                    if (cnt_r == CNT_W'(1)) begin
                        state_r     <= WAIT_LOCK;
                        cnt_r       <= CNT_W'(LOCK_TIMEOUT_CYC);
                        stab_r      <= {STB_W{1'b0}};
                        pll_reset_r <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    // Stable lock is checked first so it wins over a coincident timeout.
                    if (stab_done_s) begin
                        state_r <= DELAY;
                        cnt_r   <= CNT_W'(RELEASE_DLY_CYC);
                    end else if (cnt_r == CNT_W'(1)) begin
                        state_r     <= PLL_RST;
                        cnt_r       <= CNT_W'(PLL_RST_CYC);
                        pll_reset_r <= 1'b1;
                        tmo_r       <= sat_inc(tmo_r);
                    end else begin
                        cnt_r  <= cnt_r - CNT_W'(1);
                        stab_r <= stab_nxt_s;
                    end
                end
                DELAY: begin
                    if (!lk_s) begin
                        state_r <= WAIT_LOCK;
                        cnt_r   <= CNT_W'(LOCK_TIMEOUT_CYC);
                        stab_r  <= {STB_W{1'b0}};
                    end else if (cnt_r == CNT_W'(1)) begin
                        state_r     <= RUN;
                        sys_rst_n_r <= 1'b1;
                        locked_r    <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!lk_s) begin
                        state_r     <= PLL_RST;
                        cnt_r       <= CNT_W'(PLL_RST_CYC);
                        pll_reset_r <= 1'b1;
                        sys_rst_n_r <= 1'b0;
                        locked_r    <= 1'b0;
                        loss_r      <= sat_inc(loss_r);
                    end else begin
                        state_r <= RUN;
                    end
                end
                default: begin
                    state_r     <= PLL_RST;
                    cnt_r       <= CNT_W'(PLL_RST_CYC);
                    stab_r      <= {STB_W{1'b0}};
                    pll_reset_r <= 1'b1;
                    sys_rst_n_r <= 1'b0;
                    locked_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pll_reset_o   = pll_reset_r;
    assign bus.sys_rst_n_o   = sys_rst_n_r;
    assign bus.locked_o      = locked_r;
    assign bus.loss_cnt_o    = loss_r;
    assign bus.timeout_cnt_o = tmo_r;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Scoreboard bench for pll_rst_seq: expected pulse widths, latencies and counts
// are queued when stimulus is applied and compared when the DUT responds.
module tb_pll_rst_seq;
    import pll_seq_pkg::*;

    localparam int P_RST = 4;
    localparam int P_STB = 8;
    localparam int P_TMO = 32;
    localparam int P_DLY = 5;
    localparam int BOUND = 200;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   exp_q[$];
    int   n;

    always #5 clk = ~clk;

    pll_rst_seq_if bus ();

    pll_rst_seq #(
        .PLL_RST_CYC      (P_RST),
        .LOCK_STABLE_CYC  (P_STB),
        .LOCK_TIMEOUT_CYC (P_TMO),
        .RELEASE_DLY_CYC  (P_DLY)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    task automatic chk_eq(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_pop(input string tag, input int obs);
        if (exp_q.size() == 0) chk_eq({tag, "_noexp"}, obs, -1);
        else                   chk_eq(tag, obs, exp_q.pop_front());
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycles pll_reset_o stays at lvl, starting from the current sample.
    task automatic cnt_rst_lvl(input logic lvl, output int cnt);
        cnt = 0;
        while (bus.pll_reset_o === lvl && cnt < BOUND) begin
            cnt++;
            step();
        end
    endtask

    task automatic cnt_until_sys(input logic lvl, output int cnt);
        cnt = 0;
        while (bus.sys_rst_n_o !== lvl && cnt < BOUND) begin
            step();
            cnt++;
        end
    endtask

    task automatic cnt_until_locked(input logic lvl, output int cnt);
        cnt = 0;
        while (bus.locked_o !== lvl && cnt < BOUND) begin
            step();
            cnt++;
        end
    endtask

    task automatic apply_reset(input logic lock);
        rst_n = 1'b0;
        bus.pll_lock_i = lock;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset values and first sequence (steady lock from 3 cycles after release of PLL reset)
        bus.pll_lock_i = 1'b0;
        step();
        chk_eq("rst_pll_reset", bus.pll_reset_o, 1);
        chk_eq("rst_sys_rst_n", bus.sys_rst_n_o, 0);
        chk_eq("rst_locked", bus.locked_o, 0);
        chk_eq("rst_loss", bus.loss_cnt_o, 0);
        chk_eq("rst_timeout", bus.timeout_cnt_o, 0);
        apply_reset(1'b0);
        exp_q.push_back(P_RST);
        cnt_rst_lvl(1'b1, n);
        chk_pop("a_rst_width", n);
        repeat (3) step();
        bus.pll_lock_i = 1'b1;
        exp_q.push_back(2 + P_STB + P_DLY);
        cnt_until_sys(1'b1, n);
        chk_pop("a_release_lat", n);
        chk_eq("a_locked", bus.locked_o, 1);
        chk_eq("a_pll_reset_low", bus.pll_reset_o, 0);

        // Lock loss in RUN
        bus.pll_lock_i = 1'b0;
        exp_q.push_back(3);
        cnt_until_sys(1'b0, n);
        chk_pop("d_drop_lat", n);
        chk_eq("d_locked", bus.locked_o, 0);
        chk_eq("d_loss", bus.loss_cnt_o, 1);
        exp_q.push_back(P_RST);
        cnt_rst_lvl(1'b1, n);
        chk_pop("d_rst_width", n);

        // Async reset in the middle of DELAY, then full restart with lock held
        bus.pll_lock_i = 1'b1;
        repeat (2 + P_STB + 2) step();
        chk_eq("e_in_delay_sys", bus.sys_rst_n_o, 0);
        chk_eq("e_in_delay_prst", bus.pll_reset_o, 0);
        #2 rst_n = 1'b0;
        #1;
        chk_eq("e_async_pll_reset", bus.pll_reset_o, 1);
        chk_eq("e_async_sys", bus.sys_rst_n_o, 0);
        chk_eq("e_async_locked", bus.locked_o, 0);
        chk_eq("e_async_loss", bus.loss_cnt_o, 0);
        step();
        step();
        rst_n = 1'b1;
        exp_q.push_back(P_RST);
        cnt_rst_lvl(1'b1, n);
        chk_pop("e_rst_width", n);
        exp_q.push_back(P_STB + P_DLY);
        cnt_until_sys(1'b1, n);
        chk_pop("e_restart_lat", n);

        // Lock never asserts: periodic PLL reset with timeout count
        apply_reset(1'b0);
        exp_q.push_back(P_RST);
        cnt_rst_lvl(1'b1, n);
        chk_pop("b_rst_width0", n);
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back(P_TMO);
            cnt_rst_lvl(1'b0, n);
            chk_pop("b_wait_len", n);
            exp_q.push_back(k);
            chk_pop("b_timeout_cnt", bus.timeout_cnt_o);
            exp_q.push_back(P_RST);
            cnt_rst_lvl(1'b1, n);
            chk_pop("b_rst_width", n);
        end
        chk_eq("b_sys_low", bus.sys_rst_n_o, 0);

        // One-cycle lock glitch at stable count 6 restarts the stable count
        apply_reset(1'b0);
        exp_q.push_back(P_RST);
        cnt_rst_lvl(1'b1, n);
        chk_pop("c_rst_width", n);
        repeat (3) step();
        bus.pll_lock_i = 1'b1;
        repeat (6) step();
        bus.pll_lock_i = 1'b0;
        step();
        bus.pll_lock_i = 1'b1;
        exp_q.push_back(2 + P_STB + P_DLY);
        cnt_until_sys(1'b1, n);
        chk_pop("c_release_lat", n);
        chk_eq("c_timeout", bus.timeout_cnt_o, 0);

        // 300 lock losses in RUN: loss count saturates at 255
        apply_reset(1'b0);
        for (int i = 1; i <= 300; i++) begin
            bus.pll_lock_i = 1'b1;
            cnt_until_locked(1'b1, n);
            chk_eq("f_locked_up", bus.locked_o, 1);
            bus.pll_lock_i = 1'b0;
            exp_q.push_back((i > 255) ? 255 : i);
            cnt_until_locked(1'b0, n);
            chk_pop("f_loss_cnt", bus.loss_cnt_o);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_rst_seq.md
PLL_RST_SEQ -- requirements
Module: pll_rst_seq

Interface
REQ-001 SHALL have parameter PLL_RST_CYC, default 16, PLL reset pulse length in clk cycles (>=1).
REQ-002 SHALL have parameter LOCK_STABLE_CYC, default 1024, cycles of continuous synced lock required before release (>=1).
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYC, default 65536, max cycles spent waiting for lock before PLL is reset again (> LOCK_STABLE_CYC).
REQ-004 SHALL have parameter RELEASE_DLY_CYC, default 256, cycles between stable lock and system reset release (>=1).
REQ-005 clk  input  1  free-running 27 MHz board reference clock; the same clock drives the PLL CLKIN, so it never depends on PLL output.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 pll_lock_i  input  1  PLL LOCK output, asynchronous to clk.
REQ-008 pll_reset_o  output  1  drives PLL RESET, active-high.
REQ-009 sys_rst_n_o  output  1  reset for logic clocked by the PLL output, active-low.
REQ-010 locked_o  output  1  high only in state RUN.
REQ-011 loss_cnt_o  output  8  count of lock losses in RUN, saturating.
REQ-012 timeout_cnt_o  output  8  count of lock-wait timeouts, saturating.

Function
REQ-013 pll_lock_i SHALL pass through a 2-flop synchronizer; all decisions use synced lock (lk), adding 2 cycles of latency.
REQ-014 FSM states SHALL be PLL_RST, WAIT_LOCK, DELAY, RUN; one shared down-counter, width sized for the largest parameter.
REQ-015 PLL_RST: pll_reset_o=1 for exactly PLL_RST_CYC cycles, then -> WAIT_LOCK.
REQ-016 WAIT_LOCK: stable counter increments while lk=1, clears to 0 on any cycle with lk=0; on reaching LOCK_STABLE_CYC -> DELAY.
REQ-017 WAIT_LOCK: a timeout counter runs from entry; on reaching LOCK_TIMEOUT_CYC without stable lock -> PLL_RST and timeout_cnt_o increments (saturates at 255).
REQ-018 If stable and timeout conditions occur in the same cycle, stable lock SHALL win (-> DELAY).
REQ-019 DELAY: counts RELEASE_DLY_CYC cycles then -> RUN; lk=0 on any cycle -> WAIT_LOCK with counters cleared, no loss count.
REQ-020 RUN: sys_rst_n_o=1, locked_o=1; lk=0 -> PLL_RST next cycle, loss_cnt_o increments (saturates at 255).
REQ-021 sys_rst_n_o and locked_o SHALL be registered, =0 in all states except RUN, and deassert the first cycle the FSM leaves RUN.
REQ-022 pll_reset_o SHALL be registered and glitch-free; 1 only in PLL_RST.
REQ-023 Counters SHALL never wrap; loss_cnt_o/timeout_cnt_o hold at 255.

Reset
REQ-024 rst_n low SHALL asynchronously force: state PLL_RST, counter loaded with PLL_RST_CYC, pll_reset_o=1, sys_rst_n_o=0, locked_o=0, loss_cnt_o=0, timeout_cnt_o=0, synchronizer flops=0.
REQ-025 rst_n asserted in any state SHALL abort the sequence; after release, a full PLL_RST pulse of PLL_RST_CYC cycles SHALL be issued.
REQ-026 rst_n deassertion is synchronised externally; block need not re-synchronise it.

Structure
REQ-027 State encoding typedef and saturating-counter width constant (8) SHALL live in shared package pll_seq_pkg.
REQ-028 Synchronizer SHALL be a separate sub-module sync_2ff (1-bit, parameterless), reusable elsewhere.
REQ-029 Whole block SHALL be single clock domain clk; no derived or gated clocks.

Verification (PLL_RST_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=32, RELEASE_DLY_CYC=5)
REQ-030 Reset release, lock rises 3 cycles after pll_reset_o falls, stays high -> pll_reset_o high exactly 4 cycles; sys_rst_n_o rises 2+8+5 cycles (±1 for registering) after lock rise; locked_o follows.
REQ-031 Lock never asserts -> pll_reset_o re-pulses every 4+32 cycles; timeout_cnt_o = 1, 2, 3 after each expiry.
REQ-032 Lock glitches low 1 cycle at stable count 6 -> stable count restarts; release delayed by 8 further cycles.
REQ-033 Lock drops in RUN -> sys_rst_n_o=0 and locked_o=0 within 3 cycles of drop, loss_cnt_o=1, 4-cycle pll_reset_o pulse follows.
REQ-034 300 RUN-loss events forced -> loss_cnt_o saturates at 255, no wrap.
REQ-035 rst_n pulsed low mid-DELAY -> all outputs at reset values immediately (asynchronous), counts cleared, full sequence restarts.
